radix_scatter: RTL and testbench

- Downstream consumer of the snoop bucket bases.
- For one radix-sort pass, keeps a write pointer per bucket, seeded from the bases snoop produced during the previous write sweep.
- For each item read back from memory: extracts the pass's 4-bit digit, emits a destination write address = dst_base + wptr[digit], then advances that pointer. This produces a stable counting-sort scatter with no dynamic allocation.
- Sits between the radix read stream and the memory write port.

---
 rtl/radix_scatter_pkg.sv | 36 +++
 rtl/radix_digit_sel.sv | 25 ++
 rtl/radix_scatter.sv | 186 ++++++++++++++++++
 tb/tb_radix_scatter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radix_scatter_pkg.sv
// Shared radix-sort definitions: digit geometry, bucket count, FSM encoding and
// the pass-to-digit mapping used by both the scatter and snoop sides.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif
`ifndef EQUIHASH_c
`define EQUIHASH_c 24
`endif

package radix_scatter_pkg;

  localparam int RADIX_BITS  = 4;
  localparam int NUM_BUCKETS = 16;
  localparam int KEY_W       = `EQUIHASH_c;

  // Passes 0..4 take a nibble, pass 5 takes a single high bit, others fall back.
  localparam int LAST_NIBBLE_PASS = 4;
  localparam int HI_BIT_PASS      = 5;
  localparam int HI_BIT_IDX       = 20;
  localparam int DEFAULT_NIBBLE   = 1;

  localparam int DIGIT_SRC_W = HI_BIT_IDX + 1;
  localparam int DIGIT_USE_W = (KEY_W < DIGIT_SRC_W) ? KEY_W : DIGIT_SRC_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scatter_state_e;

endpackage

// File: rtl/radix_digit_sel.sv
// Combinational digit extractor: selects the 4-bit bucket index of a key for a
// given radix pass. Bits of the key above the hash width arrive as zero.
module radix_digit_sel
  import radix_scatter_pkg::*;
(
  input  logic [DIGIT_SRC_W-1:0] key,
  input  logic [3:0]             pass_cnt,
  output logic [RADIX_BITS-1:0]  digit
);

  // pass-to-digit mapping
  always_comb begin
    digit = key[DEFAULT_NIBBLE*RADIX_BITS +: RADIX_BITS];
    case (pass_cnt)
      4'd0:    digit = key[3:0];
      4'd1:    digit = key[7:4];
      4'd2:    digit = key[11:8];
      4'd3:    digit = key[15:12];
      4'd4:    digit = key[19:16];
      4'd5:    digit = {3'b000, key[HI_BIT_IDX]};
      default: digit = key[DEFAULT_NIBBLE*RADIX_BITS +: RADIX_BITS];
    endcase
  end

endmodule

// File: rtl/radix_scatter.sv
// Counting-sort scatter: per-bucket write pointers seeded from snoop bases turn
// each item into a destination write. Optional SCATTER_BOUNDS_CHECK_EN adds a sticky overflow flag.
module radix_scatter
  import radix_scatter_pkg::*;
#(
  parameter int ADDR_W = `MEM_ADDR_WIDTH,
  parameter int DATA_W = `MEM_DATA_WIDTH
) (
  input  logic                          eclk,
  input  logic                          rstb,
  input  logic                          pass_start,
  input  logic [3:0]                    pass_cnt,
  input  logic [ADDR_W-1:0]             item_total,
  input  logic [ADDR_W-1:0]             dst_base,
  input  logic [NUM_BUCKETS*ADDR_W-1:0] bucket_base_flat,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [DATA_W-1:0]             out_data,
  output logic                          busy,
  output logic                          pass_done,
  output logic                          bounds_err
);

  scatter_state_e state_r, state_nxt_s;

  logic [3:0]            pass_cnt_r;
  logic [ADDR_W-1:0]     item_total_r;
  logic [ADDR_W-1:0]     dst_base_r;
  logic [ADDR_W-1:0]     count_r;
  logic [ADDR_W-1:0]     wptr_r [NUM_BUCKETS];
  logic                  out_valid_r;
  logic [ADDR_W-1:0]     out_addr_r;
  logic [DATA_W-1:0]     out_data_r;
  logic                  busy_r;
  logic                  pass_done_r;

  logic                  seed_s;
  logic                  accept_s;
  logic                  in_ready_s;
  logic [DIGIT_SRC_W-1:0] key_s;
  logic [RADIX_BITS-1:0] digit_s;
  logic [ADDR_W-1:0]     wptr_sel_s;
  logic [ADDR_W-1:0]     count_inc_s;

  assign seed_s      = (state_r == ST_IDLE) && pass_start;
  assign in_ready_s  = (state_r == ST_RUN) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign wptr_sel_s  = wptr_r[digit_s];
  assign count_inc_s = count_r + ADDR_W'(1'b1);

  // hash bits beyond the key width read as zero for digit selection
  always_comb begin
    key_s = '0;
    key_s[DIGIT_USE_W-1:0] = in_data[DIGIT_USE_W-1:0];
  end

  radix_digit_sel u_digit_sel (
    .key      (key_s),
    .pass_cnt (pass_cnt_r),
    .digit    (digit_s)
  );

  // pass sequencing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pass_start) state_nxt_s = ST_LOAD;
        else            state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (item_total_r == '0) state_nxt_s = ST_DONE;
        else                    state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (accept_s && (count_inc_s == item_total_r)) state_nxt_s = ST_DRAIN;
        else                                           state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!out_valid_r || out_ready) state_nxt_s = ST_DONE;
        else                           state_nxt_s = ST_DRAIN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register plus status flags registered from the next state
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      pass_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_RUN) ||
                     (state_nxt_s == ST_DRAIN);
      pass_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  // per-pass configuration latched at pass start
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      pass_cnt_r   <= 4'd0;
      item_total_r <= '0;
      dst_base_r   <= '0;
    end else if (seed_s) begin
      pass_cnt_r   <= pass_cnt;
      item_total_r <= item_total;
      dst_base_r   <= dst_base;
    end
  end

  // bucket write pointers; the accept path reads and bumps the same entry in one cycle
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      for (int k = 0; k < NUM_BUCKETS; k++) wptr_r[k] <= '0;
    end else if (seed_s) begin
      for (int k = 0; k < NUM_BUCKETS; k++) wptr_r[k] <= bucket_base_flat[k*ADDR_W +: ADDR_W];
    end else if (accept_s) begin
      wptr_r[digit_s] <= wptr_sel_s + ADDR_W'(1'b1);
    end
  end

  // accepted item counter
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      count_r <= '0;
    end else if (seed_s) begin
      count_r <= '0;
    end else if (accept_s) begin
      count_r <= count_inc_s;
    end
  end

  // output register; a same-cycle accept refills it while the old write drains
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= '0;
      out_data_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_addr_r  <= dst_base_r + wptr_sel_s;
      out_data_r  <= in_data;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef SCATTER_BOUNDS_CHECK_EN
  logic [ADDR_W-1:0] limit_r [NUM_BUCKETS];
  logic              bounds_err_r;

  // bucket k may grow up to the base of bucket k+1; the last one up to item_total
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      for (int k = 0; k < NUM_BUCKETS; k++) limit_r[k] <= '0;
      bounds_err_r <= 1'b0;
    end else if (seed_s) begin
      for (int k = 0; k < NUM_BUCKETS-1; k++) limit_r[k] <= bucket_base_flat[(k+1)*ADDR_W +: ADDR_W];
      limit_r[NUM_BUCKETS-1] <= item_total;
      bounds_err_r <= 1'b0;
    end else if (accept_s && (wptr_sel_s >= limit_r[digit_s])) begin
      bounds_err_r <= 1'b1;
    end
  end

  assign bounds_err = bounds_err_r;
`else
  assign bounds_err = 1'b0;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_addr  = out_addr_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign pass_done = pass_done_r;

endmodule

// File: tb/tb_radix_scatter.sv
// Scoreboard bench for radix_scatter: expected writes are queued at accept time
// and retired against the write port handshake.
`timescale 1ns/1ps
module tb_radix_scatter;
  import radix_scatter_pkg::*;

  localparam int AW = `MEM_ADDR_WIDTH;
  localparam int DW = `MEM_DATA_WIDTH;
`ifdef SCATTER_BOUNDS_CHECK_EN
  localparam logic EXP_BERR = 1'b1;
`else
  localparam logic EXP_BERR = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic                  eclk = 1'b0;
  logic                  rstb;
  logic                  pass_start;
  logic [3:0]            pass_cnt;
  logic [AW-1:0]         item_total;
  logic [AW-1:0]         dst_base;
  logic [16*AW-1:0]      bucket_base_flat;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [AW-1:0]         out_addr;
  logic [DW-1:0]         out_data;
  logic                  busy;
  logic                  pass_done;
  logic                  bounds_err;

  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt, done_cnt, tcyc, last_out_cyc, done_cyc;

  exp_t          exp_q[$];
  logic [DW-1:0] send_q[$];
  logic [AW-1:0] seen_q[$];
  logic [AW-1:0] bases_v [16];
  logic [AW-1:0] m_wptr [16];
  logic [AW-1:0] m_dst;
  logic [3:0]    m_pass;
  logic [AW-1:0] exp_addr [3];

  radix_scatter dut (
    .eclk             (eclk),
    .rstb             (rstb),
    .pass_start       (pass_start),
    .pass_cnt         (pass_cnt),
    .item_total       (item_total),
    .dst_base         (dst_base),
    .bucket_base_flat (bucket_base_flat),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_data         (out_data),
    .busy             (busy),
    .pass_done        (pass_done),
    .bounds_err       (bounds_err)
  );

  always #5 eclk = ~eclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_digit(input logic [DW-1:0] d, input logic [3:0] p);
    case (p)
      4'd0:    return d[3:0];
      4'd1:    return d[7:4];
      4'd2:    return d[11:8];
      4'd3:    return d[15:12];
      4'd4:    return d[19:16];
      4'd5:    return {3'b000, d[20]};
      default: return d[7:4];
    endcase
  endfunction

  // one clock: inputs already driven after negedge; judge handshakes just before posedge
  task automatic tick();
    exp_t e;
    logic [3:0] d;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out_data", out_data, e.data);
        seen_q.push_back(out_addr);
        last_out_cyc = tcyc;
      end else begin
        chk("hold_addr", out_addr, exp_q[0].addr);
        chk("hold_data", out_data, exp_q[0].data);
        chk("stall_in_ready", in_ready, 1'b0);
      end
    end
    if (in_valid && in_ready) begin
      d = exp_digit(in_data, m_pass);
      e.addr = m_dst + m_wptr[d];
      e.data = in_data;
      exp_q.push_back(e);
      m_wptr[d] = m_wptr[d] + 1'b1;
      acc_cnt++;
      void'(send_q.pop_front());
    end
    if (pass_done) begin
      done_cnt++;
      done_cyc = tcyc;
    end
    tcyc++;
    @(posedge eclk);
    @(negedge eclk);
  endtask

  task automatic start_pass(input logic [3:0] p, input logic [AW-1:0] tot, input logic [AW-1:0] dst);
    for (int k = 0; k < 16; k++) bucket_base_flat[k*AW +: AW] = bases_v[k];
    pass_cnt = p;
    item_total = tot;
    dst_base = dst;
    pass_start = 1'b1;
    m_pass = p;
    m_dst = dst;
    m_wptr = bases_v;
    acc_cnt = 0;
    done_cnt = 0;
    seen_q.delete();
    @(posedge eclk);
    @(negedge eclk);
    pass_start = 1'b0;
    #1;
    chk("load_busy", busy, 1'b1);
  endtask

  // drive send_q until the pass completes; optional out_ready stall window
  task automatic stream(input int budget, input int stall_from, input int stall_len);
    int cyc = 0;
    while (cyc < budget && !(send_q.size() == 0 && exp_q.size() == 0 && done_cnt > 0)) begin
      in_valid = (send_q.size() != 0);
      in_data = in_valid ? send_q[0] : '0;
      out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_in_budget", cyc < budget, 1'b1);
    #1;
    chk("done_pulse_end", pass_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rstb = 1'b0; pass_start = 1'b0; pass_cnt = 4'd0; item_total = '0; dst_base = '0;
    bucket_base_flat = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tcyc = 0; last_out_cyc = 0; done_cyc = 0; m_pass = 4'd0; m_dst = '0;
    for (int k = 0; k < 16; k++) m_wptr[k] = '0;
    repeat (3) @(negedge eclk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pass_done", pass_done, 1'b0);
    chk("rst_bounds_err", bounds_err, 1'b0);
    chk("rst_out_addr", out_addr, '0);
    chk("rst_out_data", out_data, '0);
    rstb = 1'b1;
    @(negedge eclk);

    // basic scatter
    bases_v[0] = 'd0; bases_v[1] = 'd2;
    for (int k = 2; k < 16; k++) bases_v[k] = 'd3;
    start_pass(4'd0, 'd3, 'h100);
    send_q = '{'h1234_5671, 'h0000_00F0, 'h89AB_CDE0};
    stream(50, 1000, 0);
    exp_addr = '{'h102, 'h100, 'h101};
    chk("basic_count", seen_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("basic_addr", seen_q[i], exp_addr[i]);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_done_lat", done_cyc, last_out_cyc + 1);

    // backpressure mid-stream
    for (int k = 0; k < 16; k++) bases_v[k] = AW'(k * 4);
    start_pass(4'd2, 'd8, 'h200);
    for (int i = 0; i < 8; i++) send_q.push_back(DW'($urandom));
    stream(100, 3, 5);
    chk("bp_accepted", acc_cnt, 8);
    chk("bp_emitted", seen_q.size(), 8);
    chk("bp_done_cnt", done_cnt, 1);

    // pass 5: only bit 20 selects the bucket
    bases_v[0] = 'd0; bases_v[1] = 'd7;
    for (int k = 2; k < 16; k++) bases_v[k] = 'd9;
    start_pass(4'd5, 'd3, 'h40);
    send_q.push_back(DW'($urandom) | DW'(32'h0010_0000));
    send_q.push_back(DW'($urandom) & ~DW'(32'h0010_0000));
    send_q.push_back(DW'($urandom) | DW'(32'h0010_0000));
    stream(50, 1000, 0);
    exp_addr = '{'h47, 'h40, 'h48};
    for (int i = 0; i < 3; i++) chk("p5_addr", seen_q[i], exp_addr[i]);

    // empty pass
    start_pass(4'd0, 'd0, 'h10);
    @(posedge eclk); @(negedge eclk); #1;
    chk("empty_done", pass_done, 1'b1);
    chk("empty_out_valid", out_valid, 1'b0);
    chk("empty_busy", busy, 1'b0);
    @(posedge eclk); @(negedge eclk); #1;
    chk("empty_done_once", pass_done, 1'b0);
    @(negedge eclk);

    // reset mid-RUN after 2 of 4 items
    for (int k = 0; k < 16; k++) bases_v[k] = AW'(k);
    start_pass(4'd0, 'd4, 'h300);
    send_q = '{'h3, 'h5, 'h7, 'h9};
    for (int c = 0; c < 20 && acc_cnt < 2; c++) begin
      in_valid = 1'b1; in_data = send_q[0]; out_ready = 1'b1;
      tick();
    end
    chk("mid_accepted", acc_cnt, 2);
    in_valid = 1'b0;
    rstb = 1'b0;
    @(posedge eclk); @(negedge eclk); #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_done", pass_done, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    rstb = 1'b1;
    exp_q.delete(); send_q.delete();
    done_cnt = 0;
    repeat (5) tick();
    chk("mid_no_done", done_cnt, 0);
    for (int k = 0; k < 16; k++) bases_v[k] = AW'(16 - k);
    start_pass(4'd1, 'd3, 'h500);
    send_q = '{'h20, 'hF0, 'h20};
    stream(50, 1000, 0);
    exp_addr = '{'h50E, 'h501, 'h50F};
    for (int i = 0; i < 3; i++) chk("post_rst_addr", seen_q[i], exp_addr[i]);
    chk("post_rst_done_cnt", done_cnt, 1);

    // bounds overflow on bucket 0
    bases_v[0] = 'd0;
    for (int k = 1; k < 16; k++) bases_v[k] = 'd1;
    start_pass(4'd0, 'd2, 'h0);
    send_q = '{'h10, 'h20};
    for (int c = 0; c < 20 && acc_cnt < 1; c++) begin
      in_valid = 1'b1; in_data = send_q[0]; out_ready = 1'b1;
      tick();
    end
    #1;
    chk("bnd_first", bounds_err, 1'b0);
    stream(50, 1000, 0);
    chk("bnd_second", bounds_err, EXP_BERR);
    repeat (3) tick();
    chk("bnd_sticky", bounds_err, EXP_BERR);
    start_pass(4'd0, 'd0, 'h0);
    chk("bnd_cleared", bounds_err, 1'b0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
